// File: rtl/xgmii_tx_arbiter.sv
// xgmii_tx_arbiter: packet-granular round-robin arbiter that shares one 32-bit
// AXIS MAC TX path between N_SRC sources. Grants are held for a whole packet.
// A watchdog aborts a granted packet whose source stalls mid-frame.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   s_t*_i / s_tready_o per-source AXIS slave bundles (source k at lane k)
//   m_t*_o / m_tready_i AXIS master towards the MAC
//   en_mask_i           per-source enable for new grants
//   grant_o             one-hot current grant (0 when idle)
//   busy_o              high whenever not idle
//   pkt_done_o          pulse when a packet's final beat is accepted or drained
//   abort_o             pulse when the watchdog fires
//   abort_cnt_o         saturating abort counter

module xgmii_tx_arbiter #(
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [32*N_SRC-1:0]  s_tdata_i,
    input  logic [2*N_SRC-1:0]   s_tvldb_i,
    input  logic [N_SRC-1:0]     s_tvalid_i,
    output logic [N_SRC-1:0]     s_tready_o,
    input  logic [N_SRC-1:0]     s_tlast_i,
    input  logic [N_SRC-1:0]     s_tuser_i,
    output logic [31:0]          m_tdata_o,
    output logic [1:0]           m_tvldb_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tlast_o,
    output logic                 m_tuser_o,
    input  logic [N_SRC-1:0]     en_mask_i,
    output logic [N_SRC-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 pkt_done_o,
    output logic                 abort_o,
    output logic [CNT_W-1:0]     abort_cnt_o
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RST = PW'(N_SRC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Selected source view
    logic [31:0]       sel_data;
    logic [1:0]        sel_vldb;
    logic              sel_valid;
    logic              sel_last;
    logic              sel_user;
    logic [N_SRC-1:0]  gnt_oh;

    // Round-robin pick
    logic [N_SRC-1:0]  req;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand;

    logic              beat_acc;
    logic              wd_fire;

    always_comb begin
        sel_data  = '0;
        sel_vldb  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        gnt_oh    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (gidx_q == PW'(k)) begin
                sel_data  = s_tdata_i[32*k +: 32];
                sel_vldb  = s_tvldb_i[2*k +: 2];
                sel_valid = s_tvalid_i[k];
                sel_last  = s_tlast_i[k];
                sel_user  = s_tuser_i[k];
                gnt_oh[k] = 1'b1;
            end
        end
    end

    // Scan starting just after the last-served source so it gets lowest
    // priority next time.
    always_comb begin
        req        = s_tvalid_i & en_mask_i;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = PW'((int'(ptr_q) + i) % N_SRC);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign beat_acc = sel_valid & m_tready_i;
    // Only a missing source beat counts as starvation; MAC backpressure does not.
    assign wd_fire  = (state_q == PASS) && !sel_valid && (wd_q == WD_MAX);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            ptr_q   <= PTR_RST;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (beat_acc) begin
                    wd_d = '0;
                    if (sel_last) begin
                        ptr_d   = gidx_q;
                        state_d = IDLE;
                    end
                end else if (!sel_valid) begin
                    if (wd_q == WD_MAX) begin
                        wd_d    = '0;
                        state_d = ABORT;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            ABORT: begin
                if (m_tready_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sel_valid && sel_last) begin
                    ptr_d   = gidx_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        m_tdata_o  = '0;
        m_tvldb_o  = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        m_tuser_o  = 1'b0;
        s_tready_o = '0;
        grant_o    = '0;
        pkt_done_o = 1'b0;
        abort_o    = 1'b0;
        busy_o     = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
            end
            PASS: begin
                grant_o    = gnt_oh;
                m_tdata_o  = sel_data;
                m_tvldb_o  = sel_vldb;
                m_tvalid_o = sel_valid;
                m_tlast_o  = sel_last;
                m_tuser_o  = sel_user;
                s_tready_o = gnt_oh & {N_SRC{m_tready_i}};
                pkt_done_o = beat_acc & sel_last;
                abort_o    = wd_fire;
            end
            ABORT: begin
                // Injected terminating beat marks the frame as errored.
                grant_o    = gnt_oh;
                m_tvalid_o = 1'b1;
                m_tlast_o  = 1'b1;
                m_tuser_o  = 1'b1;
                m_tvldb_o  = 2'd3;
            end
            DRAIN: begin
                // Source remainder is swallowed without reaching the MAC.
                grant_o    = gnt_oh;
                s_tready_o = gnt_oh;
                pkt_done_o = sel_valid & sel_last;
            end
        endcase
    end

    assign abort_cnt_o = cnt_q;

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// tb_xgmii_tx_arbiter: scoreboard bench for xgmii_tx_arbiter.
// Source queues feed the DUT; a negedge monitor checks MAC-side beats.
module tb_xgmii_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int CW  = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  vldb;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct packed {
    logic [3:0]  gnt;
    logic        user;
    logic        last;
    logic [1:0]  vldb;
    logic [31:0] data;
  } exp_t;

  logic            clk;
  logic            rst_i;
  logic [32*N-1:0] s_tdata_i;
  logic [2*N-1:0]  s_tvldb_i;
  logic [N-1:0]    s_tvalid_i;
  logic [N-1:0]    s_tready_o;
  logic [N-1:0]    s_tlast_i;
  logic [N-1:0]    s_tuser_i;
  logic [31:0]     m_tdata_o;
  logic [1:0]      m_tvldb_o;
  logic            m_tvalid_o;
  logic            m_tready_i;
  logic            m_tlast_o;
  logic            m_tuser_o;
  logic [N-1:0]    en_mask_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic            pkt_done_o;
  logic            abort_o;
  logic [CW-1:0]   abort_cnt_o;

  xgmii_tx_arbiter #(
    .N_SRC  (N),
    .TIMEOUT(TMO),
    .CNT_W  (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .s_tdata_i  (s_tdata_i),
    .s_tvldb_i  (s_tvldb_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tready_o (s_tready_o),
    .s_tlast_i  (s_tlast_i),
    .s_tuser_i  (s_tuser_i),
    .m_tdata_o  (m_tdata_o),
    .m_tvldb_o  (m_tvldb_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tlast_o  (m_tlast_o),
    .m_tuser_o  (m_tuser_o),
    .en_mask_i  (en_mask_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .pkt_done_o (pkt_done_o),
    .abort_o    (abort_o),
    .abort_cnt_o(abort_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t     srcq [N][$];
  exp_t      sb [$];
  int        done_cyc [$];
  logic      mrdy = 1'b1;
  logic [N-1:0] mask = '1;
  logic [N-1:0] fire = '0;

  int n_chk = 0;
  int n_fail = 0;
  int done_n = 0;
  int abort_n = 0;
  int acc_n = 0;
  int acc_cyc = 0;
  int abort_gap = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Source driver: pop accepted beats, present queue heads.
  initial begin
    s_tdata_i  = '0;
    s_tvldb_i  = '0;
    s_tvalid_i = '0;
    s_tlast_i  = '0;
    s_tuser_i  = '0;
    m_tready_i = 1'b1;
    en_mask_i  = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
        if (fire[k] && !rst_i && srcq[k].size() > 0)
          void'(srcq[k].pop_front());
      for (int k = 0; k < N; k++) begin
        if (srcq[k].size() > 0) begin
          s_tvalid_i[k]         = 1'b1;
          s_tdata_i[32*k +: 32] = srcq[k][0].data;
          s_tvldb_i[2*k +: 2]   = srcq[k][0].vldb;
          s_tlast_i[k]          = srcq[k][0].last;
          s_tuser_i[k]          = srcq[k][0].user;
        end else begin
          s_tvalid_i[k]         = 1'b0;
          s_tdata_i[32*k +: 32] = '0;
          s_tvldb_i[2*k +: 2]   = '0;
          s_tlast_i[k]          = 1'b0;
          s_tuser_i[k]          = 1'b0;
        end
      end
      m_tready_i = mrdy;
      en_mask_i  = mask;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      fire = s_tvalid_i & s_tready_o;
      if (!rst_i) begin
        if (pkt_done_o) begin
          done_n++;
          done_cyc.push_back(cyc);
        end
        if (abort_o) begin
          abort_n++;
          abort_gap = cyc - acc_cyc;
        end
        if (m_tvalid_o && m_tready_i) begin
          acc_n++;
          acc_cyc = cyc;
          a = {grant_o, m_tuser_o, m_tlast_o, m_tvldb_o, m_tdata_o};
          if (sb.size() == 0) begin
            chk("unexpected_beat", a, 0);
          end else begin
            e = sb.pop_front();
            chk("beat", a, e);
          end
        end
      end
    end
  end

  task automatic load(input int k, input int pid, input int first,
                      input int cnt, input logic lst, input logic ul,
                      input logic ex);
    beat_t b;
    exp_t  e;
    for (int i = first; i < first + cnt; i++) begin
      b.data = {8'(k), 8'(pid), 16'(i)};
      b.last = lst && (i == first + cnt - 1);
      b.vldb = b.last ? 2'(pid) : 2'd3;
      b.user = b.last & ul;
      srcq[k].push_back(b);
      if (ex) begin
        e.gnt  = 4'(1 << k);
        e.user = b.user;
        e.last = b.last;
        e.vldb = b.vldb;
        e.data = b.data;
        sb.push_back(e);
      end
    end
  endtask

  task automatic push_abort(input int k);
    exp_t e;
    e.gnt  = 4'(1 << k);
    e.user = 1'b1;
    e.last = 1'b1;
    e.vldb = 2'd3;
    e.data = '0;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int lim, input int budget, input string nm);
    int t = 0;
    while (sb.size() > lim && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_sb_wait"}, (sb.size() > lim) ? 1 : 0, 0);
  endtask

  task automatic wait_acc(input int tgt, input int budget, input string nm);
    int t = 0;
    while (acc_n < tgt && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_acc_wait"}, (acc_n < tgt) ? 1 : 0, 0);
  endtask

  task automatic wait_abort(input int tgt, input int budget, input string nm);
    int t = 0;
    while (abort_n < tgt && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_abort_wait"}, (abort_n < tgt) ? 1 : 0, 0);
  endtask

  task automatic wait_src(input int k, input int budget, input string nm);
    int t = 0;
    while (srcq[k].size() > 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_src_wait"}, srcq[k].size(), 0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout: cycle %0d reached, expected end before it", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int d0;
    int a0;
    int c0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_mvalid", m_tvalid_o, 0);
    chk("rst_sready", s_tready_o, 0);
    chk("rst_cnt", abort_cnt_o, 0);
    chk("rst_done", pkt_done_o, 0);
    #2 rst_i = 1'b0;
    repeat (2) @(posedge clk);

    // T1: sources 0 and 2 with 16-beat packets
    done_cyc.delete();
    d0 = done_n;
    load(0, 1, 1, 16, 1'b1, 1'b0, 1'b1);
    load(2, 2, 1, 16, 1'b1, 1'b1, 1'b1);
    wait_sb(0, 200, "t1");
    chk("t1_done", done_n - d0, 2);
    if (done_cyc.size() == 2)
      chk("t1_gap", done_cyc[1] - done_cyc[0], 17);
    else
      chk("t1_ndone", done_cyc.size(), 2);

    // Serve source 3 so it becomes last-served
    load(3, 3, 1, 2, 1'b1, 1'b0, 1'b1);
    wait_sb(0, 50, "t1b");
    repeat (2) @(posedge clk);

    // T2: all four sources, 3-beat packets, order 0,1,2,3,0
    done_cyc.delete();
    load(0, 10, 1, 3, 1'b1, 1'b0, 1'b1);
    load(1, 11, 1, 3, 1'b1, 1'b0, 1'b1);
    load(2, 12, 1, 3, 1'b1, 1'b0, 1'b1);
    load(3, 13, 1, 3, 1'b1, 1'b0, 1'b1);
    load(0, 14, 1, 3, 1'b1, 1'b0, 1'b1);
    wait_sb(0, 200, "t2");
    if (done_cyc.size() == 5) begin
      for (int i = 1; i < 5; i++)
        chk("t2_period", done_cyc[i] - done_cyc[i-1], 4);
    end else begin
      chk("t2_ndone", done_cyc.size(), 5);
    end
    repeat (2) @(posedge clk);

    // T3: source 1 stalls after beat 5 -> abort, then drain
    d0 = done_n;
    a0 = abort_n;
    load(1, 20, 1, 5, 1'b0, 1'b0, 1'b1);
    push_abort(1);
    wait_abort(a0 + 1, 300, "t3");
    chk("t3_wd_cycles", abort_gap, TMO);
    @(posedge clk);
    #1;
    chk("t3_cnt", abort_cnt_o, 1);
    load(1, 20, 6, 5, 1'b1, 1'b0, 1'b0);
    wait_src(1, 50, "t3");
    repeat (2) @(posedge clk);
    #1;
    chk("t3_sb_left", sb.size(), 0);
    chk("t3_done", done_n - d0, 1);
    chk("t3_aborts", abort_n - a0, 1);
    chk("t3_idle", busy_o, 0);

    // T4: MAC backpressure mid-packet never aborts
    d0 = done_n;
    a0 = abort_n;
    c0 = acc_n;
    load(2, 30, 1, 8, 1'b1, 1'b0, 1'b1);
    wait_acc(c0 + 3, 50, "t4");
    mrdy = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("t4_busy", busy_o, 1);
    chk("t4_grant", grant_o, 4'b0100);
    chk("t4_no_abort", abort_n - a0, 0);
    mrdy = 1'b1;
    wait_sb(0, 50, "t4");
    chk("t4_done", done_n - d0, 1);
    chk("t4_cnt", abort_cnt_o, 1);
    repeat (2) @(posedge clk);

    // T5: mask bit 1 cleared mid-packet
    d0 = done_n;
    c0 = acc_n;
    load(1, 40, 1, 6, 1'b1, 1'b0, 1'b1);
    wait_acc(c0 + 2, 50, "t5");
    mask = 4'b1101;
    wait_sb(0, 50, "t5a");
    load(1, 41, 1, 4, 1'b1, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_masked_grant", grant_o, 0);
    chk("t5_masked_busy", busy_o, 0);
    load(3, 42, 1, 3, 1'b1, 1'b0, 1'b1);
    load(1, 41, 1, 4, 1'b1, 1'b0, 1'b0);
    srcq[1].delete();
    load(1, 41, 1, 4, 1'b1, 1'b0, 1'b1);
    wait_sb(4, 50, "t5b");
    mask = '1;
    wait_sb(0, 50, "t5c");
    chk("t5_done", done_n - d0, 3);
    repeat (2) @(posedge clk);

    // T6: reset during beat 3
    c0 = acc_n;
    load(2, 50, 1, 8, 1'b1, 1'b0, 1'b1);
    wait_acc(c0 + 2, 50, "t6");
    #3 rst_i = 1'b1;
    #1;
    chk("t6_grant", grant_o, 0);
    chk("t6_mvalid", m_tvalid_o, 0);
    chk("t6_busy", busy_o, 0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_i = 1'b0;
    #1;
    chk("t6_cnt", abort_cnt_o, 0);
    load(1, 51, 1, 3, 1'b1, 1'b0, 1'b0);
    load(0, 52, 1, 3, 1'b1, 1'b0, 1'b1);
    load(1, 51, 1, 3, 1'b1, 1'b0, 1'b0);
    srcq[1].delete();
    load(1, 51, 1, 3, 1'b1, 1'b0, 1'b1);
    wait_sb(0, 50, "t6");
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_arbiter.md
Name: xgmii_tx_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one 32-bit AXIS TX MAC path (axis2xgmii32 input side) between N_SRC upstream AXIS sources.
- Locks the grant for a whole packet and passes beats combinationally once granted.
- Watchdog aborts a granted packet whose source stalls mid-frame: injects a terminating beat with tuser=1, then drains the source's remainder.
- Sits between per-queue TX FIFOs and the MAC TX path.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
TIMEOUT, 64, source-starvation cycles mid-packet before abort (>=2)
CNT_W, 16, width of abort counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
s_tdata_i  in  32*N_SRC  source data, source k at [32k+31:32k]
s_tvldb_i  in  2*N_SRC  last-beat valid-byte code per source (0..3 = 1..4 bytes)
s_tvalid_i  in  N_SRC  source valid
s_tready_o  out  N_SRC  source ready
s_tlast_i  in  N_SRC  source last beat
s_tuser_i  in  N_SRC  source error flag
m_tdata_o  out  32  to MAC tdata
m_tvldb_o  out  2  to MAC tvldb
m_tvalid_o  out  1  to MAC tvalid
m_tready_i  in  1  from MAC tready
m_tlast_o  out  1  to MAC tlast
m_tuser_o  out  1  to MAC tuser
en_mask_i  in  N_SRC  per-source arbitration enable
grant_o  out  N_SRC  one-hot current grant, 0 when idle
busy_o  out  1  high in any state but IDLE
pkt_done_o  out  1  one-cycle pulse when a packet's final beat is accepted by MAC or drained
abort_o  out  1  one-cycle pulse on entry to ABORT
abort_cnt_o  out  CNT_W  saturating count of aborts

Behaviour:
- Reset (async assert; deassert synchronised by clk_i): state IDLE, grant_o=0, last-served pointer=N_SRC-1 so source 0 has first priority, abort_cnt_o=0, all outputs low; watchdog counter=0.
- States: IDLE, PASS, ABORT, DRAIN.
- IDLE: req = s_tvalid_i & en_mask_i. If req!=0, register grant to first requesting index after last-served pointer (modulo N_SRC); go PASS. The grant costs one cycle: m_tvalid_o=0 and all s_tready_o=0 in IDLE.
- PASS, granted source g:
  - m_* data/valid/last/user = source g's signals, combinational; s_tready_o[g]=m_tready_i; other readies 0.
  - Beat accepted = s_tvalid[g] & m_tready_i.
  - Accepted beat with tlast: pkt_done_o=1, pointer<=g, grant cleared, next IDLE. Back-to-back packets therefore have 1 idle cycle between them.
- Watchdog (PASS only):
  - Counts cycles with s_tvalid[g]=0; clears on any accepted beat.
  - Cycles with s_tvalid[g]=1 & m_tready_i=0 do not count (MAC backpressure).
  - Reaching TIMEOUT-1 while still starved: next state ABORT; abort_o pulses; abort_cnt_o increments, saturating at all-ones.
- ABORT: m_tvalid_o=1, m_tlast_o=1, m_tuser_o=1, m_tdata_o=0, m_tvldb_o=3; all s_tready_o=0. Hold until m_tready_i=1, then go DRAIN.
- DRAIN: s_tready_o[g]=1, m_tvalid_o=0. On s_tvalid[g]&s_tlast[g]: pkt_done_o=1, pointer<=g, next IDLE. DRAIN has no timeout.
- en_mask_i only gates new grants; clearing a bit mid-packet does not abort that packet.
- Aborted packets are not reported via m_tuser_o beyond the injected beat; the source's residual data is discarded.
- Outputs m_tvldb_o/m_tdata_o are don't-care when m_tvalid_o=0, but drive 0 in IDLE/DRAIN.
- Single-beat packets are passed unmodified; minimum 2 beats is an upstream requirement.
- Reset mid-packet: returns to IDLE immediately; no terminating beat is generated.

Test Plan:
- Sources 0 and 2 each hold a 16-beat packet, mask=all, m_tready_i=1 -> source 0 served first (grant_o=0001, 16 beats), 1 idle cycle, then grant_o=0100; two pkt_done_o pulses.
- All 4 sources request continuously with 3-beat packets -> grant order 0,1,2,3,0; each packet takes 4 cycles (3 beats + 1 idle).
- Granted source drops tvalid after beat 5, TIMEOUT=64 -> abort_o at starved cycle 64, one m_* beat with tlast=1/tuser=1/tdata=0/tvldb=3, abort_cnt_o=1; source then sends beats 6..10 with tlast on 10 -> all accepted with m_tvalid_o=0, pkt_done_o once, then IDLE.
- m_tready_i low for 200 cycles while the source holds tvalid mid-packet -> no abort; data resumes intact.
- Mask bit 1 cleared while source 1 is mid-packet -> packet completes; source 1 is not granted again while masked, even when it is the only requester.
- Assert rst_i during PASS beat 3 -> grant_o=0, m_tvalid_o=0, busy_o=0 immediately; after release, source 0 has priority.
